// File: rtl/ibex_pext_simd_mac_if.sv
// Start/operand/result bundle between the ID stage (master) and the P-ext SIMD MAC (slave).
interface ibex_pext_simd_mac_if;
   logic        en_i;
   logic [1:0]  op_i;
   logic [1:0]  signed_i;
   logic        kill_i;
   logic [31:0] operand_a_i;
   logic [31:0] operand_b_i;
   logic [31:0] operand_rd_i;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] result_o;
   logic        set_ov_o;

   modport master (
      output en_i, op_i, signed_i, kill_i, operand_a_i, operand_b_i, operand_rd_i,
      input  ready_o, valid_o, result_o, set_ov_o
   );

   modport slave (
      input  en_i, op_i, signed_i, kill_i, operand_a_i, operand_b_i, operand_rd_i,
      output ready_o, valid_o, result_o, set_ov_o
   );
endinterface

// File: rtl/ibex_pext_simd_mac.sv
// Multicycle packed-SIMD multiply-accumulate (dot products with accumulator, per-lane multiply).
// Define PEXT_MAC_SAT_EN to clamp dot-op results to 32 bits and drive set_ov_o.
module ibex_pext_simd_mac #(
   parameter int ELEN = 8,
   parameter int NMUL = 1
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   ibex_pext_simd_mac_if.slave bus
);
   localparam int NLANES = 32 / ELEN;
   localparam int NCYC   = NLANES / NMUL;
   localparam int CW     = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam int PW     = 2 * ELEN + 2;
   localparam int AW     = 36;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic [1:0] {
      OP_DOTP    = 2'b00,
      OP_DOTN    = 2'b01,
      OP_LANEMUL = 2'b10,
      OP_DOT0    = 2'b11
   } op_e;

   state_e                state_q;
   logic [CW-1:0]         cnt_q;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [31:0]           a_q, b_q;
   logic [31:0]           lm_q, lm_d;
   logic [31:0]           res_q, res_d;
   op_e                   op_q;
   logic [1:0]            sgn_q;
   logic                  ov_q, ov_d;
   logic                  ready_q, valid_q;
   logic                  start, last;

   logic [4:0]            base;
   logic [ELEN-1:0]       la, lb;
   logic signed [ELEN:0]  ea, eb;
   logic signed [PW-1:0]  prod;

   // Lanes cnt*NMUL .. cnt*NMUL+NMUL-1 are folded into the accumulator this cycle.
   always_comb begin
      acc_d = acc_q;
      lm_d  = lm_q;
      base  = '0;
      la    = '0;
      lb    = '0;
      ea    = '0;
      eb    = '0;
      prod  = '0;
      for (int unsigned l = 0; l < NMUL; l++) begin
         base = 5'((32'(cnt_q) * NMUL + l) * ELEN);
         la   = a_q[base +: ELEN];
         lb   = b_q[base +: ELEN];
         ea   = {sgn_q[1] & la[ELEN-1], la};
         eb   = {sgn_q[0] & lb[ELEN-1], lb};
         prod = PW'(ea) * PW'(eb);
         if (op_q == OP_DOTN) acc_d = acc_d - AW'(prod);
         else                 acc_d = acc_d + AW'(prod);
         lm_d[base +: ELEN] = prod[ELEN-1:0];
      end
   end

`ifdef PEXT_MAC_SAT_EN
   localparam logic signed [AW-1:0] SMAX = 36'sh07FFFFFFF;
   localparam logic signed [AW-1:0] SMIN = 36'shF80000000;
   localparam logic signed [AW-1:0] UMAX = 36'sh0FFFFFFFF;
`endif

   always_comb begin
      ov_d  = 1'b0;
      res_d = acc_d[31:0];
      if (op_q == OP_LANEMUL) begin
         res_d = lm_d;
      end
`ifdef PEXT_MAC_SAT_EN
      else if (sgn_q != 2'b00) begin
         if (acc_d > SMAX) begin
            res_d = 32'h7FFF_FFFF;
            ov_d  = 1'b1;
         end else if (acc_d < SMIN) begin
            res_d = 32'h8000_0000;
            ov_d  = 1'b1;
         end
      end else begin
         if (acc_d[AW-1]) begin
            res_d = 32'h0000_0000;
            ov_d  = 1'b1;
         end else if (acc_d > UMAX) begin
            res_d = 32'hFFFF_FFFF;
            ov_d  = 1'b1;
         end
      end
`endif
   end

   assign last  = (cnt_q == CW'(NCYC - 1));
   // A kill in DONE must win over a same-cycle start; a kill in IDLE is ignored.
   assign start = bus.en_i & ((state_q == IDLE) | ((state_q == DONE) & ~bus.kill_i));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         lm_q    <= '0;
         res_q   <= '0;
         op_q    <= OP_DOTP;
         sgn_q   <= '0;
         ov_q    <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            BUSY: begin
               if (bus.kill_i) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= acc_d;
                  lm_q  <= lm_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (last) begin
                     state_q <= DONE;
                     ready_q <= 1'b1;
                     valid_q <= 1'b1;
                     res_q   <= res_d;
                     ov_q    <= ov_d;
                     cnt_q   <= '0;
                  end
               end
            end
            default: begin
               if (start) begin
                  state_q <= BUSY;
                  ready_q <= 1'b0;
                  cnt_q   <= '0;
                  a_q     <= bus.operand_a_i;
                  b_q     <= bus.operand_b_i;
                  op_q    <= op_e'(bus.op_i);
                  sgn_q   <= bus.signed_i;
                  lm_q    <= '0;
                  acc_q   <= bus.op_i[1] ? '0 : AW'($signed(bus.operand_rd_i));
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.ready_o  = ready_q;
   assign bus.valid_o  = valid_q;
   assign bus.result_o = res_q;
   assign bus.set_ov_o = ov_q;
endmodule

// File: tb/tb_ibex_pext_simd_mac.sv
// Directed bench for ibex_pext_simd_mac: an 8-bit/1-multiplier and a 16-bit/2-multiplier instance.
module tb_ibex_pext_simd_mac;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   ibex_pext_simd_mac_if b8 ();
   ibex_pext_simd_mac_if b16 ();

   ibex_pext_simd_mac #(.ELEN(8),  .NMUL(1)) u_mac8  (.clk_i(clk), .rst_ni(rst_n), .bus(b8));
   ibex_pext_simd_mac #(.ELEN(16), .NMUL(2)) u_mac16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16));

   task automatic start8(input logic [1:0] op, input logic [1:0] sg,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
      b8.op_i = op; b8.signed_i = sg;
      b8.operand_a_i = a; b8.operand_b_i = b; b8.operand_rd_i = rd;
      b8.en_i = 1'b1;
      @(posedge clk); #1;
      b8.en_i = 1'b0;
   endtask

   task automatic start16(input logic [1:0] op, input logic [1:0] sg,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rd);
      b16.op_i = op; b16.signed_i = sg;
      b16.operand_a_i = a; b16.operand_b_i = b; b16.operand_rd_i = rd;
      b16.en_i = 1'b1;
      @(posedge clk); #1;
      b16.en_i = 1'b0;
   endtask

   task automatic wait8(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!b8.valid_o && cyc < 20);
   endtask

   task automatic wait16(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!b16.valid_o && cyc < 20);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vecs++; if (b8.ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready8: got %b expected 1", b8.ready_o); end
      vecs++; if (b8.valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid8: got %b expected 0", b8.valid_o); end
      vecs++; if (b8.result_o !== 32'h0) begin errs++; $display("FAIL reset_result8: got %h expected 00000000", b8.result_o); end
      vecs++; if (b8.set_ov_o !== 1'b0) begin errs++; $display("FAIL reset_ov8: got %b expected 0", b8.set_ov_o); end
      vecs++; if (b16.ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready16: got %b expected 1", b16.ready_o); end
      vecs++; if (b16.result_o !== 32'h0) begin errs++; $display("FAIL reset_result16: got %h expected 00000000", b16.result_o); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_dotp_basic();
      int cyc, busy;
      start8(2'b00, 2'b11, 32'h01020304, 32'h01010101, 32'h00000010);
      cyc = 0; busy = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (b8.ready_o === 1'b0) busy++;
      end while (!b8.valid_o && cyc < 20);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL dotp_latency: got %0d expected 5", cyc); end
      vecs++; if (busy !== 4) begin errs++; $display("FAIL dotp_ready_low: got %0d expected 4", busy); end
      vecs++; if (b8.result_o !== 32'h0000001A) begin errs++; $display("FAIL dotp_result: got %h expected 0000001a", b8.result_o); end
      vecs++; if (b8.set_ov_o !== 1'b0) begin errs++; $display("FAIL dotp_ov: got %b expected 0", b8.set_ov_o); end
      vecs++; if (b8.ready_o !== 1'b1) begin errs++; $display("FAIL dotp_ready_done: got %b expected 1", b8.ready_o); end
      @(negedge clk);
      vecs++; if (b8.valid_o !== 1'b0) begin errs++; $display("FAIL dotp_valid_pulse: got %b expected 0", b8.valid_o); end
      vecs++; if (b8.result_o !== 32'h0000001A) begin errs++; $display("FAIL dotp_result_hold: got %h expected 0000001a", b8.result_o); end
   endtask

   task automatic test_dotp_sat();
      int cyc;
      logic [31:0] er;
      logic eo;
`ifdef PEXT_MAC_SAT_EN
      er = 32'h7FFFFFFF; eo = 1'b1;
`else
      er = 32'h8000FFFF; eo = 1'b0;
`endif
      start8(2'b00, 2'b11, 32'h80808080, 32'h80808080, 32'h7FFFFFFF);
      wait8(cyc);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL sat_latency: got %0d expected 5", cyc); end
      vecs++; if (b8.result_o !== er) begin errs++; $display("FAIL sat_result: got %h expected %h", b8.result_o, er); end
      vecs++; if (b8.set_ov_o !== eo) begin errs++; $display("FAIL sat_ov: got %b expected %b", b8.set_ov_o, eo); end
   endtask

   task automatic test_dotn_unsigned();
      int cyc;
      logic [31:0] er;
      logic eo;
`ifdef PEXT_MAC_SAT_EN
      er = 32'h00000000; eo = 1'b1;
`else
      er = 32'hFFFC07FC; eo = 1'b0;
`endif
      start8(2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      wait8(cyc);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL dotn_latency: got %0d expected 5", cyc); end
      vecs++; if (b8.result_o !== er) begin errs++; $display("FAIL dotn_result: got %h expected %h", b8.result_o, er); end
      vecs++; if (b8.set_ov_o !== eo) begin errs++; $display("FAIL dotn_ov: got %b expected %b", b8.set_ov_o, eo); end
   endtask

   task automatic test_lanemul16();
      int cyc;
      start16(2'b10, 2'b00, 32'h00030005, 32'h00070009, 32'h00000000);
      wait16(cyc);
      vecs++; if (cyc !== 2) begin errs++; $display("FAIL lanemul_latency: got %0d expected 2", cyc); end
      vecs++; if (b16.result_o !== 32'h0015002D) begin errs++; $display("FAIL lanemul_result: got %h expected 0015002d", b16.result_o); end
      vecs++; if (b16.set_ov_o !== 1'b0) begin errs++; $display("FAIL lanemul_ov: got %b expected 0", b16.set_ov_o); end
      // (-1*3) + (2*4) + 5 = 10
      start16(2'b00, 2'b11, 32'hFFFF0002, 32'h00030004, 32'h00000005);
      wait16(cyc);
      vecs++; if (cyc !== 2) begin errs++; $display("FAIL dotp16_latency: got %0d expected 2", cyc); end
      vecs++; if (b16.result_o !== 32'h0000000A) begin errs++; $display("FAIL dotp16_result: got %h expected 0000000a", b16.result_o); end
   endtask

   task automatic test_en_ignored();
      int cyc;
      start8(2'b11, 2'b11, 32'h02020202, 32'h03030303, 32'h00000000);
      b8.en_i = 1'b1; b8.op_i = 2'b00; b8.operand_a_i = 32'hFFFFFFFF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b8.en_i = 1'b0;
      wait8(cyc);
      vecs++; if (cyc !== 3) begin errs++; $display("FAIL busy_en_latency: got %0d expected 3", cyc); end
      vecs++; if (b8.result_o !== 32'h00000018) begin errs++; $display("FAIL busy_en_result: got %h expected 00000018", b8.result_o); end
   endtask

   task automatic test_kill();
      int cyc;
      start8(2'b00, 2'b11, 32'h01020304, 32'h01010101, 32'h00000010);
      @(posedge clk); #1;
      b8.kill_i = 1'b1;
      @(posedge clk); #1;
      b8.kill_i = 1'b0;
      @(negedge clk);
      vecs++; if (b8.ready_o !== 1'b1) begin errs++; $display("FAIL kill_ready: got %b expected 1", b8.ready_o); end
      vecs++; if (b8.valid_o !== 1'b0) begin errs++; $display("FAIL kill_valid: got %b expected 0", b8.valid_o); end
      vecs++; if (b8.result_o !== 32'h00000018) begin errs++; $display("FAIL kill_result_hold: got %h expected 00000018", b8.result_o); end
      @(negedge clk);
      vecs++; if (b8.valid_o !== 1'b0) begin errs++; $display("FAIL kill_no_valid: got %b expected 0", b8.valid_o); end
      start8(2'b00, 2'b11, 32'h05060708, 32'h01010101, 32'h00000100);
      wait8(cyc);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL after_kill_latency: got %0d expected 5", cyc); end
      vecs++; if (b8.result_o !== 32'h0000011A) begin errs++; $display("FAIL after_kill_result: got %h expected 0000011a", b8.result_o); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      start8(2'b00, 2'b11, 32'h01020304, 32'h01010101, 32'h00000010);
      wait8(cyc);
      vecs++; if (b8.result_o !== 32'h0000001A) begin errs++; $display("FAIL b2b_first: got %h expected 0000001a", b8.result_o); end
      start8(2'b11, 2'b00, 32'h02020202, 32'h03030303, 32'h00000000);
      wait8(cyc);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL b2b_latency: got %0d expected 5", cyc); end
      vecs++; if (b8.result_o !== 32'h00000018) begin errs++; $display("FAIL b2b_second: got %h expected 00000018", b8.result_o); end
   endtask

   task automatic test_kill_idle_done();
      int cyc;
      @(negedge clk);
      b8.kill_i = 1'b1;
      start8(2'b11, 2'b00, 32'h01010101, 32'h04040404, 32'h00000000);
      b8.kill_i = 1'b0;
      wait8(cyc);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL kill_idle_latency: got %0d expected 5", cyc); end
      vecs++; if (b8.result_o !== 32'h00000010) begin errs++; $display("FAIL kill_idle_result: got %h expected 00000010", b8.result_o); end
      b8.kill_i = 1'b1;
      start8(2'b11, 2'b00, 32'h02020202, 32'h03030303, 32'h00000000);
      b8.kill_i = 1'b0;
      @(negedge clk);
      vecs++; if (b8.ready_o !== 1'b1) begin errs++; $display("FAIL kill_done_ready: got %b expected 1", b8.ready_o); end
      repeat (5) @(negedge clk);
      vecs++; if (b8.result_o !== 32'h00000010) begin errs++; $display("FAIL kill_done_hold: got %h expected 00000010", b8.result_o); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      start8(2'b00, 2'b11, 32'h01020304, 32'h01010101, 32'h00000010);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      vecs++; if (b8.ready_o !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b expected 1", b8.ready_o); end
      vecs++; if (b8.valid_o !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b expected 0", b8.valid_o); end
      vecs++; if (b8.result_o !== 32'h0) begin errs++; $display("FAIL midrst_result: got %h expected 00000000", b8.result_o); end
      vecs++; if (b8.set_ov_o !== 1'b0) begin errs++; $display("FAIL midrst_ov: got %b expected 0", b8.set_ov_o); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start8(2'b11, 2'b00, 32'h02020202, 32'h03030303, 32'h00000000);
      wait8(cyc);
      vecs++; if (cyc !== 5) begin errs++; $display("FAIL postrst_latency: got %0d expected 5", cyc); end
      vecs++; if (b8.result_o !== 32'h00000018) begin errs++; $display("FAIL postrst_result: got %h expected 00000018", b8.result_o); end
   endtask

   initial begin
      b8.en_i = 1'b0;  b8.kill_i = 1'b0;  b8.op_i = 2'b00;  b8.signed_i = 2'b00;
      b8.operand_a_i = '0;  b8.operand_b_i = '0;  b8.operand_rd_i = '0;
      b16.en_i = 1'b0; b16.kill_i = 1'b0; b16.op_i = 2'b00; b16.signed_i = 2'b00;
      b16.operand_a_i = '0; b16.operand_b_i = '0; b16.operand_rd_i = '0;
      test_reset();
      test_dotp_basic();
      test_dotp_sat();
      test_dotn_unsigned();
      test_lanemul16();
      test_en_ignored();
      test_kill();
      test_back_to_back();
      test_kill_idle_done();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
